// File: rtl/leaf_pkg.sv
// Shared definitions for the leaf egress arbiter: packet field layout,
// destination table entry and output register state.
package leaf_pkg;

    localparam int PAYLOAD_BITS  = 32;
    localparam int NUM_LEAF_BITS = 5;
    localparam int NUM_PORT_BITS = 4;
    localparam int NUM_ADDR_BITS = 7;
    localparam int PACKET_BITS   = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS;
    localparam int BODY_BITS     = PACKET_BITS - 1;

    localparam int PAYLOAD_LSB = 0;
    localparam int ADDR_LSB    = PAYLOAD_LSB + PAYLOAD_BITS;
    localparam int PORT_LSB    = ADDR_LSB + NUM_ADDR_BITS;
    localparam int LEAF_LSB    = PORT_LSB + NUM_PORT_BITS;
    localparam int VALID_BIT   = LEAF_LSB + NUM_LEAF_BITS;

    typedef struct packed {
        logic                     valid;
        logic [NUM_LEAF_BITS-1:0] leaf;
        logic [NUM_PORT_BITS-1:0] dport;
    } dest_cfg_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    // Everything below the valid bit, in wire order.
    function automatic logic [BODY_BITS-1:0] pack_body(
        input logic [NUM_LEAF_BITS-1:0] leaf,
        input logic [NUM_PORT_BITS-1:0] dport,
        input logic [NUM_ADDR_BITS-1:0] seq,
        input logic [PAYLOAD_BITS-1:0]  payload
    );
        return {leaf, dport, seq, payload};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr,
// wrapping around to ptr itself last.
module rr_arbiter #(
    parameter int N        = 2,
    parameter int IDX_BITS = 1
) (
    input  logic [N-1:0]        req,
    input  logic [IDX_BITS-1:0] ptr,
    output logic [N-1:0]        grant,
    output logic [IDX_BITS-1:0] idx,
    output logic                any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // Upper segment (above ptr) has priority over the wrapped segment.
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (i > int'(ptr))) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                idx      = IDX_BITS'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (i <= int'(ptr))) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                idx      = IDX_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Round-robin egress scheduler: stamps user payloads with destination and
// sequence and emits one registered packet at a time. Optional per-port
// credit flow control is enabled with LEAF_ARB_CREDIT_EN.
module leaf_out_arbiter
    import leaf_pkg::*;
#(
    parameter int NUM_OUT_PORTS = 2,
    parameter int CREDIT_BITS   = 8,
    parameter int CREDIT_INIT   = 64
) (
    input  logic                                  clk_bft,
    input  logic                                  reset,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user,
    input  logic [NUM_OUT_PORTS-1:0]              vld_user,
    output logic [NUM_OUT_PORTS-1:0]              ack_user,
    input  logic                                  cfg_we,
    input  logic [2:0]                            cfg_port,
    input  logic [NUM_LEAF_BITS-1:0]              cfg_leaf,
    input  logic [NUM_PORT_BITS-1:0]              cfg_dport,
    output logic [PACKET_BITS-1:0]                pkt_out,
    input  logic                                  pkt_rdy,
    input  logic                                  credit_vld,
    input  logic [2:0]                            credit_port,
    input  logic [CREDIT_BITS-1:0]                credit_cnt,
    output out_state_t                            dbg_state
);

    localparam int IDX_BITS = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;

    // Handshake: a payload moves when vld_user[i] and ack_user[i] are both
    // high in the same cycle; a packet leaves when pkt_out[48] and pkt_rdy are.

    dest_cfg_t                cfg_q [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] seq_q [NUM_OUT_PORTS];
    logic [IDX_BITS-1:0]      ptr_q;
    out_state_t               state_q, state_d;
    logic [BODY_BITS-1:0]     body_q, body_d;

    logic                     can_load;
    logic [NUM_OUT_PORTS-1:0] has_credit;
    logic [NUM_OUT_PORTS-1:0] eligible;
    logic [NUM_OUT_PORTS-1:0] req;
    logic [NUM_OUT_PORTS-1:0] grant;
    logic [IDX_BITS-1:0]      grant_idx;
    logic                     any_grant;

    logic [PAYLOAD_BITS-1:0]  sel_payload;
    logic [NUM_LEAF_BITS-1:0] sel_leaf;
    logic [NUM_PORT_BITS-1:0] sel_dport;
    logic [NUM_ADDR_BITS-1:0] sel_seq;

`ifdef LEAF_ARB_CREDIT_EN
    logic [CREDIT_BITS-1:0] credit_q   [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0] credit_d   [NUM_OUT_PORTS];
    logic [CREDIT_BITS:0]   credit_sum [NUM_OUT_PORTS];

    // Return and grant on the same port combine before saturation.
    always_comb begin
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            credit_sum[i] = {1'b0, credit_q[i]};
            if (credit_vld && (credit_port == 3'(i))) begin
                credit_sum[i] = credit_sum[i] + {1'b0, credit_cnt};
            end
            if (grant[i]) begin
                credit_sum[i] = credit_sum[i] - (CREDIT_BITS+1)'(1);
            end
            credit_d[i]   = credit_sum[i][CREDIT_BITS] ? '1 : credit_sum[i][CREDIT_BITS-1:0];
            has_credit[i] = (credit_q[i] != '0);
        end
    end

    always_ff @(posedge clk_bft or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                credit_q[i] <= CREDIT_BITS'(CREDIT_INIT);
            end
        end else begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                credit_q[i] <= credit_d[i];
            end
        end
    end
`else
    logic unused_credit;
    assign unused_credit = ^{credit_vld, credit_port, credit_cnt};
    assign has_credit    = '1;
`endif

    assign can_load = (state_q == OUT_EMPTY) || pkt_rdy;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            eligible[i] = vld_user[i] & cfg_q[i].valid & has_credit[i];
        end
    end

    assign req = can_load ? eligible : '0;

    rr_arbiter #(
        .N        (NUM_OUT_PORTS),
        .IDX_BITS (IDX_BITS)
    ) u_rr (
        .req   (req),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (grant_idx),
        .any   (any_grant)
    );

    assign ack_user = grant;

    always_comb begin
        sel_payload = '0;
        sel_leaf    = '0;
        sel_dport   = '0;
        sel_seq     = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (grant[i]) begin
                sel_payload = din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS];
                sel_leaf    = cfg_q[i].leaf;
                sel_dport   = cfg_q[i].dport;
                sel_seq     = seq_q[i];
            end
        end
    end

    // Output register: drain and reload happen on the same edge.
    always_comb begin
        state_d = state_q;
        body_d  = body_q;
        if (can_load) begin
            if (any_grant) begin
                state_d = OUT_FULL;
                body_d  = pack_body(sel_leaf, sel_dport, sel_seq, sel_payload);
            end else begin
                state_d = OUT_EMPTY;
                body_d  = '0;
            end
        end
    end

    always_ff @(posedge clk_bft or posedge reset) begin
        if (reset) begin
            state_q <= OUT_EMPTY;
            body_q  <= '0;
            ptr_q   <= IDX_BITS'(NUM_OUT_PORTS - 1);
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                cfg_q[i] <= '0;
                seq_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            body_q  <= body_d;
            if (any_grant) begin
                ptr_q <= grant_idx;
            end
            // A grant this cycle already read the old entry.
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                if (grant[i]) begin
                    seq_q[i] <= seq_q[i] + 1'b1;
                end
                if (cfg_we && (cfg_port == 3'(i))) begin
                    cfg_q[i] <= '{valid: 1'b1, leaf: cfg_leaf, dport: cfg_dport};
                end
            end
        end
    end

    assign pkt_out   = {(state_q == OUT_FULL), body_q};
    assign dbg_state = state_q;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed bench for leaf_out_arbiter: a per-cycle reference model of the
// arbitration rules plus hand-computed packet and ack expectations.
module tb_leaf_out_arbiter;
    import leaf_pkg::*;

    localparam int N = 2;
`ifdef LEAF_ARB_CREDIT_EN
    localparam int TB_CREDIT_INIT = 2;
`else
    localparam int TB_CREDIT_INIT = 64;
`endif

    logic                    clk_bft;
    logic                    reset;
    logic [31:0]             tb_din [N];
    logic [N*32-1:0]         din_user;
    logic [N-1:0]            vld_user;
    logic [N-1:0]            ack_user;
    logic                    cfg_we;
    logic [2:0]              cfg_port;
    logic [4:0]              cfg_leaf;
    logic [3:0]              cfg_dport;
    logic [48:0]             pkt_out;
    logic                    pkt_rdy;
    logic                    credit_vld;
    logic [2:0]              credit_port;
    logic [7:0]              credit_cnt;
    out_state_t              dbg_state;

    int n_vec = 0;
    int n_err = 0;

    assign din_user = {tb_din[1], tb_din[0]};

    leaf_out_arbiter #(
        .NUM_OUT_PORTS (N),
        .CREDIT_BITS   (8),
        .CREDIT_INIT   (TB_CREDIT_INIT)
    ) dut (
        .clk_bft     (clk_bft),
        .reset       (reset),
        .din_user    (din_user),
        .vld_user    (vld_user),
        .ack_user    (ack_user),
        .cfg_we      (cfg_we),
        .cfg_port    (cfg_port),
        .cfg_leaf    (cfg_leaf),
        .cfg_dport   (cfg_dport),
        .pkt_out     (pkt_out),
        .pkt_rdy     (pkt_rdy),
        .credit_vld  (credit_vld),
        .credit_port (credit_port),
        .credit_cnt  (credit_cnt),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk_bft = 1'b0;
        forever #5 clk_bft = ~clk_bft;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [48:0] mk(input int leaf, input int dport, input int seq, input logic [31:0] pay);
        return {1'b1, 5'(leaf), 4'(dport), 7'(seq), pay};
    endfunction

    // ---------------- reference model ----------------
    logic        m_valid;
    logic [47:0] m_body;
    int          m_ptr;
    logic        m_cfg_ok [N];
    logic [4:0]  m_leaf   [N];
    logic [3:0]  m_dport  [N];
    int          m_seq    [N];
    int          m_credit [N];
    int          m_g;
    int          m_p;
    logic [N-1:0] m_exp_ack;

    always @(negedge clk_bft) begin
        if (reset) begin
            m_valid = 1'b0;
            m_body  = '0;
            m_ptr   = N - 1;
            for (int i = 0; i < N; i++) begin
                m_cfg_ok[i] = 1'b0;
                m_leaf[i]   = '0;
                m_dport[i]  = '0;
                m_seq[i]    = 0;
                m_credit[i] = TB_CREDIT_INIT;
            end
        end
        m_g = -1;
        if (!reset && (!m_valid || pkt_rdy)) begin
            for (int k = 1; k <= N; k++) begin
                m_p = (m_ptr + k) % N;
                if (m_g < 0 && vld_user[m_p] && m_cfg_ok[m_p] && m_credit[m_p] > 0) m_g = m_p;
            end
        end
        m_exp_ack = '0;
        if (m_g >= 0) m_exp_ack[m_g] = 1'b1;
        check("model_ack", 64'(ack_user), 64'(m_exp_ack));
        check("model_pkt", 64'(pkt_out), 64'({m_valid, m_body}));
        check("model_state", 64'(dbg_state == OUT_FULL), 64'(m_valid));
        if (!reset) begin
            if (!m_valid || pkt_rdy) begin
                if (m_g >= 0) begin
                    m_valid = 1'b1;
                    m_body  = {m_leaf[m_g], m_dport[m_g], 7'(m_seq[m_g]), tb_din[m_g]};
                    m_seq[m_g] = (m_seq[m_g] + 1) % 128;
                    m_ptr   = m_g;
                end else begin
                    m_valid = 1'b0;
                    m_body  = '0;
                end
            end
            if (cfg_we && int'(cfg_port) < N) begin
                m_cfg_ok[cfg_port] = 1'b1;
                m_leaf[cfg_port]   = cfg_leaf;
                m_dport[cfg_port]  = cfg_dport;
            end
`ifdef LEAF_ARB_CREDIT_EN
            for (int i = 0; i < N; i++) begin
                if (m_g == i) m_credit[i] = m_credit[i] - 1;
                if (credit_vld && int'(credit_port) == i) m_credit[i] = m_credit[i] + int'(credit_cnt);
                if (m_credit[i] > 255) m_credit[i] = 255;
            end
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_bft);
        #1;
    endtask

    task automatic cfg_write(input int port, input int leaf, input int dport);
        cfg_we    = 1'b1;
        cfg_port  = 3'(port);
        cfg_leaf  = 5'(leaf);
        cfg_dport = 4'(dport);
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic refill();
`ifdef LEAF_ARB_CREDIT_EN
        for (int i = 0; i < N; i++) begin
            credit_vld  = 1'b1;
            credit_port = 3'(i);
            credit_cnt  = 8'd255;
            tick();
        end
        credit_vld = 1'b0;
`endif
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        refill();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acks;
        reset       = 1'b1;
        tb_din[0]   = '0;
        tb_din[1]   = '0;
        vld_user    = '0;
        cfg_we      = 1'b0;
        cfg_port    = '0;
        cfg_leaf    = '0;
        cfg_dport   = '0;
        pkt_rdy     = 1'b1;
        credit_vld  = 1'b0;
        credit_port = '0;
        credit_cnt  = '0;
        repeat (3) tick();
        @(negedge clk_bft);
        check("reset_pkt", 64'(pkt_out), 64'd0);
        check("reset_ack", 64'(ack_user), 64'd0);
        tick();
        reset = 1'b0;
        refill();
        cfg_write(0, 3, 1);

        // single port, one-cycle latency
        vld_user  = 2'b01;
        tb_din[0] = 32'hDEADBEEF;
        @(negedge clk_bft);
        check("single_ack", 64'(ack_user), 64'(2'b01));
        tick();
        vld_user = '0;
        @(negedge clk_bft);
        check("single_pkt", 64'(pkt_out), 64'(mk(3, 1, 0, 32'hDEADBEEF)));
        tick();
        @(negedge clk_bft);
        check("drained", 64'(pkt_out), 64'd0);
        tick();
        cfg_write(1, 7, 2);

        // fairness: port 0 was last served, so port 1 goes first
        vld_user = 2'b11;
        for (int c = 0; c < 8; c++) begin
            tb_din[0] = 32'(c);
            tb_din[1] = 32'(c) | 32'h100;
            @(negedge clk_bft);
            check("fair_ack", 64'(ack_user), 64'((c % 2 == 0) ? 2'b10 : 2'b01));
            tick();
        end

        // backpressure: last load was port 0, payload 7, seq 4
        pkt_rdy = 1'b0;
        repeat (5) begin
            @(negedge clk_bft);
            check("stall_ack", 64'(ack_user), 64'd0);
            check("stall_pkt", 64'(pkt_out), 64'(mk(3, 1, 4, 32'd7)));
            tick();
        end
        pkt_rdy = 1'b1;
        @(negedge clk_bft);
        check("resume_ack", 64'(ack_user), 64'(2'b10));
        tick();
        @(negedge clk_bft);
        check("resume_pkt", 64'(pkt_out), 64'(mk(7, 2, 4, 32'h107)));
        tick();
        vld_user = '0;

        // asynchronous reset with a packet in the register
        reset = 1'b1;
        #1;
        check("async_rst_pkt", 64'(pkt_out), 64'd0);
        check("async_rst_ack", 64'(ack_user), 64'd0);
        tick();
        reset = 1'b0;
        refill();
        cfg_write(0, 3, 1);

        // port 1 unconfigured; out-of-range cfg write must not configure it
        vld_user = 2'b11;
        for (int c = 0; c < 6; c++) begin
            tb_din[0] = 32'(c + 16);
            tb_din[1] = 32'(c + 32);
            if (c == 2) begin
                cfg_we    = 1'b1;
                cfg_port  = 3'd5;
                cfg_leaf  = 5'd1;
                cfg_dport = 4'd1;
            end
            @(negedge clk_bft);
            check("unconf_ack", 64'(ack_user), 64'(2'b01));
            tick();
            cfg_we = 1'b0;
        end
        vld_user = '0;

        // sequence wrap over 130 packets
        pulse_reset();
        cfg_write(0, 3, 1);
        vld_user = 2'b01;
        for (int c = 0; c < 130; c++) begin
            tb_din[0] = 32'(c);
            @(negedge clk_bft);
            if (c == 128) check("seq127_pkt", 64'(pkt_out), 64'(mk(3, 1, 127, 32'd127)));
            tick();
        end

        // config write coincident with a grant uses the old destination
        cfg_we    = 1'b1;
        cfg_port  = 3'd0;
        cfg_leaf  = 5'd9;
        cfg_dport = 4'd5;
        tb_din[0] = 32'hCAFE0001;
        @(negedge clk_bft);
        check("wrap_pkt", 64'(pkt_out), 64'(mk(3, 1, 1, 32'd129)));
        check("coinc_ack", 64'(ack_user), 64'(2'b01));
        tick();
        cfg_we    = 1'b0;
        tb_din[0] = 32'hCAFE0002;
        @(negedge clk_bft);
        check("old_dest_pkt", 64'(pkt_out), 64'(mk(3, 1, 2, 32'hCAFE0001)));
        tick();
        vld_user = '0;
        @(negedge clk_bft);
        check("new_dest_pkt", 64'(pkt_out), 64'(mk(9, 5, 3, 32'hCAFE0002)));
        tick();

`ifdef LEAF_ARB_CREDIT_EN
        // two initial credits, then a single returned credit
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cfg_write(0, 3, 1);
        vld_user = 2'b01;
        acks = 0;
        repeat (6) begin
            @(negedge clk_bft);
            if (ack_user[0]) acks++;
            tick();
        end
        check("credit_stall", 64'(acks), 64'd2);
        credit_vld  = 1'b1;
        credit_port = 3'd0;
        credit_cnt  = 8'd1;
        acks = 0;
        repeat (5) begin
            @(negedge clk_bft);
            if (ack_user[0]) acks++;
            tick();
            credit_vld = 1'b0;
        end
        check("credit_one", 64'(acks), 64'd1);
        vld_user = '0;
`else
        acks = 0;
`endif
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
